// File: rtl/uart_tx_mmio_pkg.sv
// Shared register offsets, serializer state encoding and STATUS bit positions
// for the memory-mapped UART transmitter.
package uart_tx_mmio_pkg;

  localparam logic [1:0] RegTxdata  = 2'd0;
  localparam logic [1:0] RegStatus  = 2'd1;
  localparam logic [1:0] RegBauddiv = 2'd2;
  localparam logic [1:0] RegCtrl    = 2'd3;

  localparam int unsigned StatusBusy  = 0;
  localparam int unsigned StatusFull  = 1;
  localparam int unsigned StatusEmpty = 2;
  localparam int unsigned StatusOvf   = 3;
  localparam int unsigned StatusCount = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is accepted only
// when a pop happens in the same cycle.
module uart_tx_mmio_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rptr_q];

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; empty/count gate every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: bus register file, TX FIFO and an 8N1
// serializer driving TXD LSB first.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned BAUD_DIV_RST = 868
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        CE,
  input  logic [29:0] ADDR,
  input  logic [3:0]  WSTB,
  input  logic [31:0] DATAI,
  output logic [31:0] DATAO,
  output logic        TXD
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  uart_state_e state_q, state_d;

  logic [15:0]     baud_div_q;
  logic [15:0]     baud_cnt_q;
  logic [7:0]      shreg_q;
  logic [2:0]      bit_cnt_q;
  logic            enable_q;
  logic            overflow_q;

  logic [1:0]      sel;
  logic            wr, rd;
  logic            fifo_push, fifo_pop;
  logic [7:0]      fifo_head;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic            bit_end, start_ok, busy;
  logic [31:0]     status;
  logic            unused_bits;

  assign unused_bits = ^{ADDR[29:2], DATAI[31:16]};

  // ADDR is a word address, so its two LSBs are byte-address bits [3:2].
  assign sel = ADDR[1:0];
  assign wr  = CE & (|WSTB);
  assign rd  = CE & (WSTB == 4'b0000);

  assign fifo_push = wr & (sel == RegTxdata) & WSTB[0];
  assign bit_end   = (baud_cnt_q == 16'd1);
  assign start_ok  = enable_q & ~fifo_empty;

  uart_tx_mmio_sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RSTN),
    .push      (fifo_push),
    .push_data (DATAI[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Register file
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      baud_div_q <= 16'(BAUD_DIV_RST);
      enable_q   <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (wr && sel == RegBauddiv && WSTB[1:0] == 2'b11) begin
        baud_div_q <= (DATAI[15:0] == 16'd0) ? 16'd1 : DATAI[15:0];
      end
      if (wr && sel == RegCtrl && WSTB[0]) begin
        enable_q <= DATAI[0];
      end
      if (fifo_push && fifo_full && !fifo_pop) begin
        overflow_q <= 1'b1;
      end else if (wr && sel == RegCtrl && WSTB[0] && DATAI[1]) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_comb begin
    status                 = '0;
    status[StatusBusy]     = busy;
    status[StatusFull]     = fifo_full;
    status[StatusEmpty]    = fifo_empty;
    status[StatusOvf]      = overflow_q;
    status[StatusCount+:5] = 5'(fifo_count);
  end

  always_comb begin
    DATAO = '0;
    if (rd) begin
      unique case (sel)
        RegTxdata:  DATAO = '0;
        RegStatus:  DATAO = status;
        RegBauddiv: DATAO = {16'd0, baud_div_q};
        RegCtrl:    DATAO = {31'd0, enable_q};
        default:    DATAO = '0;
      endcase
    end
  end

  // Serializer FSM: state register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Serializer FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StStart;
      StStart: if (bit_end) state_d = StData;
      StData:  if (bit_end && bit_cnt_q == 3'd7) state_d = StStop;
      StStop:  if (bit_end) state_d = start_ok ? StStart : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Serializer FSM: outputs
  always_comb begin
    TXD      = 1'b1;
    busy     = 1'b1;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy     = 1'b0;
        fifo_pop = start_ok;
      end
      StStart: TXD = 1'b0;
      StData:  TXD = shreg_q[0];
      StStop:  fifo_pop = bit_end & start_ok;
      default: TXD = 1'b1;
    endcase
  end

  // Bit timing and shift datapath; BAUDDIV is sampled only at bit starts.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      baud_cnt_q <= 16'(BAUD_DIV_RST);
    end else if (fifo_pop) begin
      shreg_q    <= fifo_head;
      bit_cnt_q  <= '0;
      baud_cnt_q <= baud_div_q;
    end else if (state_q != StIdle) begin
      if (bit_end) begin
        baud_cnt_q <= baud_div_q;
        if (state_q == StData) begin
          shreg_q   <= {1'b0, shreg_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end else begin
        baud_cnt_q <= baud_cnt_q - 1'b1;
      end
    end
  end

endmodule
